// File: rtl/light_hash_param_if.sv
// Message/digest bundle for light_hash_param.
// Char stream in with valid/ready, digest and error pulses out.
interface light_hash_param_if #(
  parameter int DIGEST_BYTES = 8
);
  logic                      msg_valid;
  logic                      msg_ready;
  logic [7:0]                msg_char;
  logic                      msg_first;
  logic                      msg_last;
  logic [8*DIGEST_BYTES-1:0] digest;
  logic                      digest_valid;
  logic                      err_invalid_char;

  modport master (
    output msg_valid,
    output msg_char,
    output msg_first,
    output msg_last,
    input  msg_ready,
    input  digest,
    input  digest_valid,
    input  err_invalid_char
  );

  modport slave (
    input  msg_valid,
    input  msg_char,
    input  msg_first,
    input  msg_last,
    output msg_ready,
    output digest,
    output digest_valid,
    output err_invalid_char
  );
endinterface

// File: rtl/light_hash_param.sv
// Lightweight char-serial hash: each accepted char runs ROUNDS
// S-box rounds over an N-byte chaining state.
module light_hash_param #(
  parameter int DIGEST_BYTES = 8,
  parameter int ROUNDS       = 4,
  parameter bit ALNUM_ONLY   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  light_hash_param_if.slave    bus
);

  localparam int N = DIGEST_BYTES;
  localparam logic [63:0] IV = 64'hEE2BC0DA140F5534;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE,
    ABSORB
  } state_t;

  function automatic logic is_alnum(
    input logic [7:0] c
  );
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h5A) ||
           (c >= 8'h61 && c <= 8'h7A);
  endfunction

  state_t         state;
  logic [7:0]     h [N];
  logic [7:0]     nxt [N];
  logic [7:0]     m;
  logic           last_q;
  logic [2:0]     rnd;
  logic [8*N-1:0] dig;
  logic           dv;
  logic           err;

  logic [7:0]     key;
  logic [8*N-1:0] nxt_flat;
  logic [8*N-1:0] h_flat;
  logic [8*N-1:0] iv_flat;
  logic           ok;

  assign ok = !ALNUM_ONLY || is_alnum(bus.msg_char);

  // rotl(m, rnd); a shift by 8 on the right half yields 0 for rnd=0
  always_comb begin
    key = 8'((m << rnd) | (m >> (4'd8 - {1'b0, rnd})));
  end

  for (genvar i = 0; i < N; i++) begin : g_byte
    assign nxt[i]             = SBOX[h[(i+1)%N] ^ key];
    assign nxt_flat[8*i +: 8] = nxt[i];
    assign h_flat[8*i +: 8]   = h[i];
    assign iv_flat[8*i +: 8]  = IV[8*(i%8) +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      for (int i = 0; i < N; i++) begin
        h[i] <= iv_flat[8*i +: 8];
      end
      m      <= '0;
      last_q <= 1'b0;
      rnd    <= '0;
      dig    <= '0;
      dv     <= 1'b0;
      err    <= 1'b0;
    end else begin
      dv  <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.msg_valid) begin
            if (bus.msg_first) begin
              for (int i = 0; i < N; i++) begin
                h[i] <= iv_flat[8*i +: 8];
              end
            end
            if (ok) begin
              m      <= bus.msg_char;
              last_q <= bus.msg_last;
              rnd    <= '0;
              state  <= ABSORB;
            end else begin
              // rejected char still closes the message
              err <= 1'b1;
              if (bus.msg_last) begin
                dv  <= 1'b1;
                dig <= bus.msg_first ? iv_flat : h_flat;
              end
            end
          end
        end
        ABSORB: begin
          for (int i = 0; i < N; i++) begin
            h[i] <= nxt[i];
          end
          rnd <= rnd + 3'd1;
          if (rnd == 3'(ROUNDS - 1)) begin
            state <= IDLE;
            rnd   <= '0;
            if (last_q) begin
              dig <= nxt_flat;
              dv  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.msg_ready        = (state == IDLE);
  assign bus.digest           = dig;
  assign bus.digest_valid     = dv;
  assign bus.err_invalid_char = err;

endmodule

// File: tb/tb_light_hash_param.sv
// Directed bench for light_hash_param: a small N=2/1-round instance
// plus a default instance checked against a behavioural hash model.
module tb_light_hash_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  light_hash_param_if #(.DIGEST_BYTES(2)) a ();
  light_hash_param_if #(.DIGEST_BYTES(8)) b ();

  light_hash_param #(
    .DIGEST_BYTES(2),
    .ROUNDS(1),
    .ALNUM_ONLY(1'b0)
  ) dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(a)
  );

  light_hash_param dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IV = 64'hEE2BC0DA140F5534;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rotl(input logic [7:0] c, input int s);
    for (int j = 0; j < s; j++) c = {c[6:0], c[7]};
    return c;
  endfunction

  // one absorbed char on the default (N=8, 4-round) configuration
  function automatic logic [63:0] mstep(input logic [63:0] h,
                                        input logic [7:0] c);
    logic [63:0] hn;
    hn = '0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++)
        hn[8*i +: 8] = SBOX[h[8*((i+1)%8) +: 8] ^ rotl(c, r % 8)];
      h = hn;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [7:0] c, input logic f, input logic l);
    @(negedge clk);
    a.msg_valid = 1'b1; a.msg_char = c; a.msg_first = f; a.msg_last = l;
    @(posedge clk);
    #1;
    a.msg_valid = 1'b0; a.msg_first = 1'b0; a.msg_last = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] c, input logic f, input logic l);
    @(negedge clk);
    b.msg_valid = 1'b1; b.msg_char = c; b.msg_first = f; b.msg_last = l;
    @(posedge clk);
    #1;
    b.msg_valid = 1'b0; b.msg_first = 1'b0; b.msg_last = 1'b0;
  endtask

  task automatic absorb_b(input logic l, input logic [63:0] expd);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ready_low", b.msg_ready, 1'b0);
      chk("dv_quiet", b.digest_valid, 1'b0);
    end
    @(negedge clk);
    chk("ready_back", b.msg_ready, 1'b1);
    chk("dv_end", b.digest_valid, l);
    chk("digest_end", b.digest, expd);
    chk("err_quiet", b.err_invalid_char, 1'b0);
    if (l) begin
      @(negedge clk);
      chk("dv_one_cycle", b.digest_valid, 1'b0);
    end
  endtask

  task automatic invalid_b(input logic l, input logic [63:0] expd);
    @(negedge clk);
    chk("inv_ready", b.msg_ready, 1'b1);
    chk("inv_err", b.err_invalid_char, 1'b1);
    chk("inv_dv", b.digest_valid, l);
    chk("inv_digest", b.digest, expd);
    @(negedge clk);
    chk("inv_err_off", b.err_invalid_char, 1'b0);
    chk("inv_dv_off", b.digest_valid, 1'b0);
  endtask

  logic [63:0] h1;
  logic [63:0] h2;

  initial begin
    rst_n = 1'b0;
    a.msg_valid = 1'b0; a.msg_char = '0; a.msg_first = 1'b0; a.msg_last = 1'b0;
    b.msg_valid = 1'b0; b.msg_char = '0; b.msg_first = 1'b0; b.msg_last = 1'b0;

    // reset state
    #2;
    chk("rst_ready_b", b.msg_ready, 1'b1);
    chk("rst_digest_b", b.digest, 64'h0);
    chk("rst_dv_b", b.digest_valid, 1'b0);
    chk("rst_err_b", b.err_invalid_char, 1'b0);
    chk("rst_digest_a", a.digest, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_a", a.msg_ready, 1'b1);
    chk("post_rst_ready_b", b.msg_ready, 1'b1);

    // N=2, 1 round: 0x00 single-char message
    drive_a(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("a0_ready_low", a.msg_ready, 1'b0);
    chk("a0_dv_low", a.digest_valid, 1'b0);
    @(negedge clk);
    chk("a0_ready", a.msg_ready, 1'b1);
    chk("a0_dv", a.digest_valid, 1'b1);
    chk("a0_digest", a.digest, 64'h18FC);
    @(negedge clk);
    chk("a0_dv_off", a.digest_valid, 1'b0);

    // N=2, 1 round: 'A'
    drive_a(8'h41, 1'b1, 1'b1);
    @(negedge clk);
    chk("aA_ready_low", a.msg_ready, 1'b0);
    @(negedge clk);
    chk("aA_dv", a.digest_valid, 1'b1);
    chk("aA_digest", a.digest, 64'h9DFA);

    // defaults: '!' rejected, digest = IV
    drive_b(8'h21, 1'b1, 1'b1);
    invalid_b(1'b1, IV);

    // "Ab1" from IV, then chained repeat
    h1 = mstep(mstep(mstep(IV, 8'h41), 8'h62), 8'h31);
    drive_b(8'h41, 1'b1, 1'b0);
    absorb_b(1'b0, IV);
    drive_b(8'h62, 1'b0, 1'b0);
    absorb_b(1'b0, IV);
    drive_b(8'h31, 1'b0, 1'b1);
    absorb_b(1'b1, h1);

    h2 = mstep(mstep(mstep(h1, 8'h41), 8'h62), 8'h31);
    drive_b(8'h41, 1'b0, 1'b0);
    absorb_b(1'b0, h1);
    drive_b(8'h62, 1'b0, 1'b0);
    absorb_b(1'b0, h1);
    drive_b(8'h31, 1'b0, 1'b1);
    absorb_b(1'b1, h2);
    chk("chain_differs", (h2 != h1), 1'b1);

    // invalid char mid-message leaves H untouched
    h1 = mstep(mstep(IV, 8'h78), 8'h79);
    drive_b(8'h78, 1'b1, 1'b0);
    absorb_b(1'b0, h2);
    drive_b(8'h23, 1'b0, 1'b0);
    invalid_b(1'b0, h2);
    drive_b(8'h79, 1'b0, 1'b1);
    absorb_b(1'b1, h1);

    // valid held high, chars churn during ABSORB
    h2 = mstep(mstep(IV, 8'h61), 8'h62);
    @(negedge clk);
    b.msg_valid = 1'b1; b.msg_char = 8'h61;
    b.msg_first = 1'b1; b.msg_last = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("churn_err", b.err_invalid_char, 1'b0);
      chk("churn_dv", b.digest_valid, 1'b0);
      chk("churn_ready", b.msg_ready, (k == 5));
      if (k == 5) begin
        b.msg_char = 8'h62; b.msg_first = 1'b0; b.msg_last = 1'b1;
      end else begin
        b.msg_char = 8'(8'h30 + k); b.msg_first = 1'b1;
        b.msg_last = (k < 5);
      end
    end
    @(negedge clk);
    b.msg_valid = 1'b0; b.msg_first = 1'b0; b.msg_last = 1'b0;
    chk("churn_dv_end", b.digest_valid, 1'b1);
    chk("churn_digest", b.digest, h2);

    // reset during round 2 of a last char
    drive_b(8'h51, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", b.msg_ready, 1'b1);
    chk("mid_rst_digest", b.digest, 64'h0);
    chk("mid_rst_dv", b.digest_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("after_rst_dv", b.digest_valid, 1'b0);
      chk("after_rst_err", b.err_invalid_char, 1'b0);
      chk("after_rst_ready", b.msg_ready, 1'b1);
    end
    drive_b(8'h21, 1'b0, 1'b1);
    invalid_b(1'b1, IV);
    h1 = mstep(IV, 8'h7A);
    drive_b(8'h7A, 1'b1, 1'b1);
    absorb_b(1'b1, h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_hash_param.md
LIGHT_HASH_PARAM -- requirements
Module: light_hash_param

Interface
REQ-001 Parameter DIGEST_BYTES, default 8, digest length N in bytes; legal range 2..16.
REQ-002 Parameter ROUNDS, default 4, compression rounds per absorbed char; legal range 1..8.
REQ-003 Parameter ALNUM_ONLY, default 1; 1 = only 0-9, A-Z, a-z are valid; 0 = every byte is valid.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 msg_valid  input  1  msg_char is offered.
REQ-007 msg_ready  output  1  block accepts a char this cycle.
REQ-008 msg_char  input  8  message byte.
REQ-009 msg_first  input  1  char starts a new message; qualified by msg_valid.
REQ-010 msg_last  input  1  char ends the message; qualified by msg_valid.
REQ-011 digest  output  8*N  digest; byte i on bits [8i+7:8i].
REQ-012 digest_valid  output  1  one-cycle pulse, digest updated.
REQ-013 err_invalid_char  output  1  one-cycle pulse, rejected char.

Function
REQ-014 Accept (handshake) SHALL occur on a rising edge with msg_valid=1 and msg_ready=1; no other edge consumes input.
REQ-015 IV SHALL be byte i = {34,55,0F,14,DA,C0,2B,EE}[i mod 8] (hex); state H[0..N-1] SHALL be loaded with the IV at reset.
REQ-016 If msg_first=1 at accept, H SHALL be treated as IV before absorbing that char. If msg_first=0, chaining SHALL continue from the current H.
REQ-017 The FSM SHALL have the states IDLE (msg_ready=1) and ABSORB (msg_ready=0).
REQ-018 IDLE -> ABSORB SHALL occur on accept of a valid char.
REQ-019 ABSORB -> IDLE SHALL occur on the edge completing round ROUNDS-1.
REQ-020 Round r (0..ROUNDS-1) SHALL take one cycle: H'[i] = SBOX(H[(i+1) mod N] XOR rotl(M, r mod 8)) for all i in parallel; SBOX is the AES forward S-box.
REQ-021 Latency SHALL be fixed: accept at edge t; rounds at edges t+1..t+ROUNDS; msg_ready=1 again in the cycle after edge t+ROUNDS.
REQ-022 If the accepted char had msg_last=1, at edge t+ROUNDS digest SHALL load H' and digest_valid SHALL be 1 for exactly one cycle.
REQ-023 Otherwise digest SHALL hold its value.
REQ-024 An invalid char (ALNUM_ONLY=1 and non-alnum) SHALL still be accepted.
REQ-025 For an invalid char: no ABSORB, H unchanged, msg_ready stays 1, err_invalid_char=1 for the one cycle after edge t.
REQ-026 Invalid char with msg_first=1 SHALL still reset H to IV.
REQ-027 Invalid char with msg_last=1 SHALL load digest from current H with digest_valid pulsed in the cycle after edge t.
REQ-028 msg_first=1 and msg_last=1 together SHALL hash a single-char message.
REQ-029 Input changes during ABSORB SHALL be ignored; the char is captured at accept.
REQ-030 Back-to-back: a new accept SHALL be possible on the first edge where msg_ready=1, giving a throughput of one char per ROUNDS+1 cycles.

Reset
REQ-031 On rst_n=0 the block SHALL immediately enter IDLE with H=IV, digest=0, digest_valid=0, err_invalid_char=0 and round counter=0.
REQ-032 msg_ready SHALL be 1 from the first cycle after reset.
REQ-033 Reset asserted mid-ABSORB SHALL abandon the char with no digest_valid and no err_invalid_char pulse.
REQ-034 All state SHALL be reset; no register SHALL rely on an initial value.

Verification
REQ-035 N=2, ROUNDS=1, ALNUM_ONLY=0; 0x00 sent with first=last=1 -> digest=16'h18FC, digest_valid one cycle at edge t+1, msg_ready low one cycle.
REQ-036 N=2, ROUNDS=1; 'A' (0x41) sent with first=last=1 -> digest=16'h9DFA.
REQ-037 Defaults; '!' sent with first=last=1 -> no ABSORB; err_invalid_char and digest_valid pulse in the cycle after accept; digest=64'hEE2BC0DA140F5534 (IV).
REQ-038 Defaults; "Ab1" streamed with first on 'A' and last on '1' -> msg_ready low 4 cycles per char; digest_valid exactly once at accept('1')+4; digest matches bit-exact reference model; repeat stream without first -> chained result differs and matches model.
REQ-039 Defaults; rst_n pulsed low at round 2 of a last-char absorb -> no digest_valid; after release msg_ready=1 and H=IV; a fresh message matches model.
REQ-040 Defaults; msg_valid held high with changing msg_char during ABSORB -> only chars present on accept edges are hashed; digest matches model.
